// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: CSR addresses, mstatus bit
// positions, the cause number of external line 0 and the trap FSM states.
package irq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // External line i reports cause IRQ_CAUSE_BASE+i and sits at mie/mip bit 16+i.
  localparam int IRQ_CAUSE_BASE = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    IN_TRAP = 1'b1
  } irq_state_t;

endpackage

// File: rtl/irq_controller_if.sv
// Core-side connection of the interrupt controller: CSR access port, mret
// strobe, resume PC and the trap outputs consumed by the PC-update logic.
//   master: core / control unit      slave: irq_controller
interface irq_controller_if;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [31:0] csr_rdata;
  logic        return_from_int;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic        interrupt_pending;
  logic        in_trap;

  modport master (
    output csr_addr, csr_wdata, csr_wen, return_from_int, pc_in,
    input  csr_rdata, pc_out, interrupt_pending, in_trap
  );

  modport slave (
    input  csr_addr, csr_wdata, csr_wen, return_from_int, pc_in,
    output csr_rdata, pc_out, interrupt_pending, in_trap
  );
endinterface

// File: rtl/irq_sync_edge.sv
// Per-line input conditioning: SYNC_STAGES-deep synchroniser followed by a
// registered rising-edge detector.
//   clk, rst_n : core clock, async active-low reset
//   irq_raw    : asynchronous request line
//   level      : synchronised level
//   rise       : one-cycle pulse on a synchronised 0->1 (always 0 in level mode)
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_raw,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = EDGE_MODE & level & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Multi-line machine-mode interrupt controller with CSR file, fixed priority
// (lowest line wins) and optional vectored dispatch.
//   clk, rst_n : core clock, async active-low reset
//   irq_lines  : raw asynchronous interrupt requests, one per line
//   bus        : CSR port, mret strobe, resume PC, trap PC and trap status
module irq_controller
  import irq_pkg::*;
#(
  parameter int                 NUM_IRQ     = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = {NUM_IRQ{1'b1}},
  parameter bit                 VECTORED_EN = 1'b1,
  parameter logic [31:0]        MTVEC_RESET = 32'h8000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines,
  irq_controller_if.slave    bus
);

  logic [NUM_IRQ-1:0] sync_level, rise;
  logic [NUM_IRQ-1:0] pend_q, pend_d, mie_q;
  logic [NUM_IRQ-1:0] mip_vec, active, win_oh;
  logic [4:0]         win_idx;
  logic [31:0]        win_cause, mtvec_q, mepc_q, mcause_q, mtvec_base;
  logic               mstatus_mie_q, mstatus_mpie_q;
  logic               take, csr_we;
  irq_state_t         state_q, state_d;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MASK[i])
    ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .irq_raw(irq_lines[i]),
      .level  (sync_level[i]),
      .rise   (rise[i])
    );
  end

  // Edge lines report their latched pend bit, level lines the live level.
  assign mip_vec = (pend_q & EDGE_MASK) | (sync_level & ~EDGE_MASK);
  assign active  = mip_vec & mie_q;
  // Isolate the lowest set bit: that line has the highest priority.
  assign win_oh  = active & (~active + 1'b1);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (win_oh[i]) win_idx = 5'(i);
    end
  end

  assign win_cause  = 32'(IRQ_CAUSE_BASE) + 32'(win_idx);
  assign mtvec_base = {mtvec_q[31:2], 2'b00};

  // mret always beats a take in the same cycle.
  assign take   = (state_q == IDLE) && mstatus_mie_q && (|active) && !bus.return_from_int;
  // The instruction carrying a CSR write is squashed when the trap is taken.
  assign csr_we = bus.csr_wen && !take;

  // Trap FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d               = state_q;
    bus.interrupt_pending = take;
    bus.in_trap           = (state_q == IN_TRAP);
    bus.pc_out            = mepc_q;
    if (bus.return_from_int) begin
      state_d = IDLE;
    end else if (take) begin
      state_d    = IN_TRAP;
      bus.pc_out = mtvec_q[0] ? (mtvec_base + (win_cause << 2)) : mtvec_base;
    end
  end

  // Pending bits: software write, then take-clear, then hardware set wins.
  always_comb begin
    pend_d = pend_q;
    if (csr_we && (bus.csr_addr == CSR_MIP)) pend_d = bus.csr_wdata[IRQ_CAUSE_BASE +: NUM_IRQ];
    if (take) pend_d = pend_d & ~win_oh;
    pend_d = (pend_d | rise) & EDGE_MASK;
  end

  // CSR file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      pend_q         <= '0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      pend_q <= pend_d;
      if (csr_we) begin
        case (bus.csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= bus.csr_wdata[MSTATUS_MIE_BIT];
            mstatus_mpie_q <= bus.csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:    mie_q    <= bus.csr_wdata[IRQ_CAUSE_BASE +: NUM_IRQ];
          CSR_MTVEC:  mtvec_q  <= {bus.csr_wdata[31:2], 1'b0,
                                   (VECTORED_EN && (bus.csr_wdata[1:0] == 2'b01))};
          CSR_MEPC:   mepc_q   <= bus.csr_wdata & ~32'h3;
          CSR_MCAUSE: mcause_q <= bus.csr_wdata;
          default: ;
        endcase
      end
      if (bus.return_from_int) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (take) begin
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
        mepc_q         <= bus.pc_in & ~32'h3;
        mcause_q       <= 32'h8000_0000 | win_cause;
      end
    end
  end

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        bus.csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        bus.csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
      end
      CSR_MIE:    bus.csr_rdata[IRQ_CAUSE_BASE +: NUM_IRQ] = mie_q;
      CSR_MTVEC:  bus.csr_rdata = mtvec_q;
      CSR_MEPC:   bus.csr_rdata = mepc_q;
      CSR_MCAUSE: bus.csr_rdata = mcause_q;
      CSR_MIP:    bus.csr_rdata[IRQ_CAUSE_BASE +: NUM_IRQ] = mip_vec;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_lines;
  logic [31:0] r;
  int checks = 0;
  int errors = 0;

  irq_controller_if bus();

  always #5 clk = ~clk;

  irq_controller #(
    .NUM_IRQ    (8),
    .SYNC_STAGES(2),
    .EDGE_MASK  (8'hF7),
    .VECTORED_EN(1'b1),
    .MTVEC_RESET(32'h8000_0100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_lines(irq_lines),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    bus.csr_addr  = addr;
    bus.csr_wdata = data;
    bus.csr_wen   = 1'b1;
    tick();
    bus.csr_wen   = 1'b0;
  endtask

  task automatic rd(input logic [11:0] addr, output logic [31:0] data);
    bus.csr_addr = addr;
    #1;
    data = bus.csr_rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq_lines = '0;
    bus.csr_addr = '0;
    bus.csr_wdata = '0;
    bus.csr_wen = 1'b0;
    bus.return_from_int = 1'b0;
    bus.pc_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    rd(CSR_MTVEC, r);   checks++; if (r !== 32'h8000_0100) begin errors++; $display("FAIL reset_mtvec got %h want %h", r, 32'h8000_0100); end
    rd(CSR_MSTATUS, r); checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_mstatus got %h want %h", r, 32'h0); end
    rd(CSR_MIE, r);     checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_mie got %h want %h", r, 32'h0); end
    rd(CSR_MEPC, r);    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_mepc got %h want %h", r, 32'h0); end
    rd(CSR_MCAUSE, r);  checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_mcause got %h want %h", r, 32'h0); end
    rd(CSR_MIP, r);     checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_mip got %h want %h", r, 32'h0); end
    rd(12'h340, r);     checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_unmapped got %h want %h", r, 32'h0); end
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL reset_ip got %b want 0", bus.interrupt_pending); end
    checks++; if (bus.in_trap !== 1'b0) begin errors++; $display("FAIL reset_in_trap got %b want 0", bus.in_trap); end
  endtask

  task automatic test_direct();
    wr(CSR_MIE, 32'h0001_0000);
    wr(CSR_MTVEC, 32'h8000_0100);
    wr(CSR_MSTATUS, 32'h0000_0008);
    bus.pc_in = 32'h8000_0040;
    irq_lines = 8'h01;
    tick();
    irq_lines = 8'h00;
    tick();
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL direct_early_ip got %b want 0", bus.interrupt_pending); end
    tick();
    checks++; if (bus.interrupt_pending !== 1'b1) begin errors++; $display("FAIL direct_ip got %b want 1", bus.interrupt_pending); end
    checks++; if (bus.pc_out !== 32'h8000_0100) begin errors++; $display("FAIL direct_pc_out got %h want %h", bus.pc_out, 32'h8000_0100); end
    // CSR write in the take cycle must be dropped
    bus.csr_addr = CSR_MTVEC;
    bus.csr_wdata = 32'h1234_5678;
    bus.csr_wen = 1'b1;
    tick();
    bus.csr_wen = 1'b0;
    checks++; if (bus.in_trap !== 1'b1) begin errors++; $display("FAIL direct_in_trap got %b want 1", bus.in_trap); end
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL direct_ip_after got %b want 0", bus.interrupt_pending); end
    rd(CSR_MEPC, r);    checks++; if (r !== 32'h8000_0040) begin errors++; $display("FAIL direct_mepc got %h want %h", r, 32'h8000_0040); end
    rd(CSR_MCAUSE, r);  checks++; if (r !== 32'h8000_0010) begin errors++; $display("FAIL direct_mcause got %h want %h", r, 32'h8000_0010); end
    rd(CSR_MSTATUS, r); checks++; if (r !== 32'h0000_0080) begin errors++; $display("FAIL direct_mstatus got %h want %h", r, 32'h80); end
    rd(CSR_MIP, r);     checks++; if (r !== 32'h0) begin errors++; $display("FAIL direct_mip got %h want %h", r, 32'h0); end
    rd(CSR_MTVEC, r);   checks++; if (r !== 32'h8000_0100) begin errors++; $display("FAIL squash_mtvec got %h want %h", r, 32'h8000_0100); end
    bus.return_from_int = 1'b1;
    #1;
    checks++; if (bus.pc_out !== 32'h8000_0040) begin errors++; $display("FAIL mret_pc_out got %h want %h", bus.pc_out, 32'h8000_0040); end
    tick();
    bus.return_from_int = 1'b0;
    checks++; if (bus.in_trap !== 1'b0) begin errors++; $display("FAIL mret_in_trap got %b want 0", bus.in_trap); end
    rd(CSR_MSTATUS, r); checks++; if (r !== 32'h0000_0088) begin errors++; $display("FAIL mret_mstatus got %h want %h", r, 32'h88); end
  endtask

  task automatic test_vectored();
    wr(CSR_MTVEC, 32'h8000_0101);
    rd(CSR_MTVEC, r); checks++; if (r !== 32'h8000_0101) begin errors++; $display("FAIL vec_mtvec got %h want %h", r, 32'h8000_0101); end
    wr(CSR_MIE, 32'h0024_0000);
    bus.pc_in = 32'h8000_0200;
    irq_lines = 8'h24;
    tick();
    irq_lines = 8'h00;
    tick();
    tick();
    checks++; if (bus.interrupt_pending !== 1'b1) begin errors++; $display("FAIL vec_ip got %b want 1", bus.interrupt_pending); end
    checks++; if (bus.pc_out !== 32'h8000_0148) begin errors++; $display("FAIL vec_pc_out2 got %h want %h", bus.pc_out, 32'h8000_0148); end
    tick();
    bus.pc_in = 32'h8000_0300;
    checks++; if (bus.in_trap !== 1'b1) begin errors++; $display("FAIL vec_in_trap got %b want 1", bus.in_trap); end
    rd(CSR_MCAUSE, r); checks++; if (r !== 32'h8000_0012) begin errors++; $display("FAIL vec_mcause2 got %h want %h", r, 32'h8000_0012); end
    rd(CSR_MIP, r);    checks++; if (r !== 32'h0020_0000) begin errors++; $display("FAIL vec_mip_pend5 got %h want %h", r, 32'h0020_0000); end
    rd(CSR_MEPC, r);   checks++; if (r !== 32'h8000_0200) begin errors++; $display("FAIL vec_mepc got %h want %h", r, 32'h8000_0200); end
    // Re-enabling MIE inside the handler must not nest
    wr(CSR_MSTATUS, 32'h0000_0088);
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL no_nest_ip got %b want 0", bus.interrupt_pending); end
    bus.return_from_int = 1'b1;
    #1;
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL mret_wins_ip got %b want 0", bus.interrupt_pending); end
    checks++; if (bus.pc_out !== 32'h8000_0200) begin errors++; $display("FAIL mret_wins_pc got %h want %h", bus.pc_out, 32'h8000_0200); end
    tick();
    bus.return_from_int = 1'b0;
    #1;
    checks++; if (bus.interrupt_pending !== 1'b1) begin errors++; $display("FAIL vec_ip5 got %b want 1", bus.interrupt_pending); end
    checks++; if (bus.pc_out !== 32'h8000_0154) begin errors++; $display("FAIL vec_pc_out5 got %h want %h", bus.pc_out, 32'h8000_0154); end
    tick();
    rd(CSR_MCAUSE, r); checks++; if (r !== 32'h8000_0015) begin errors++; $display("FAIL vec_mcause5 got %h want %h", r, 32'h8000_0015); end
    rd(CSR_MEPC, r);   checks++; if (r !== 32'h8000_0300) begin errors++; $display("FAIL vec_mepc5 got %h want %h", r, 32'h8000_0300); end
    rd(CSR_MIP, r);    checks++; if (r !== 32'h0) begin errors++; $display("FAIL vec_mip_clear got %h want %h", r, 32'h0); end
    bus.return_from_int = 1'b1;
    tick();
    bus.return_from_int = 1'b0;
  endtask

  task automatic test_mip_sw();
    wr(CSR_MIE, 32'h0);
    wr(CSR_MIP, 32'h0009_0000);
    rd(CSR_MIP, r); checks++; if (r !== 32'h0001_0000) begin errors++; $display("FAIL mip_sw_set got %h want %h", r, 32'h0001_0000); end
    wr(CSR_MIP, 32'h0);
    rd(CSR_MIP, r); checks++; if (r !== 32'h0) begin errors++; $display("FAIL mip_sw_clr got %h want %h", r, 32'h0); end
  endtask

  task automatic test_level();
    irq_lines[3] = 1'b1;
    repeat (3) tick();
    rd(CSR_MIP, r); checks++; if (r !== 32'h0008_0000) begin errors++; $display("FAIL level_high got %h want %h", r, 32'h0008_0000); end
    wr(CSR_MIP, 32'h0);
    rd(CSR_MIP, r); checks++; if (r !== 32'h0008_0000) begin errors++; $display("FAIL level_wr_ignored got %h want %h", r, 32'h0008_0000); end
    irq_lines[3] = 1'b0;
    tick();
    rd(CSR_MIP, r); checks++; if (r !== 32'h0008_0000) begin errors++; $display("FAIL level_drop_early got %h want %h", r, 32'h0008_0000); end
    tick();
    rd(CSR_MIP, r); checks++; if (r !== 32'h0) begin errors++; $display("FAIL level_drop got %h want %h", r, 32'h0); end
    checks++; if (bus.interrupt_pending !== 1'b0 || bus.in_trap !== 1'b0) begin errors++; $display("FAIL level_no_trap got ip=%b trap=%b want 0 0", bus.interrupt_pending, bus.in_trap); end
  endtask

  task automatic test_reset_mid();
    wr(CSR_MTVEC, 32'h8000_0200);
    wr(CSR_MIE, 32'h0003_0000);
    irq_lines = 8'h03;
    tick();
    irq_lines = 8'h00;
    repeat (3) tick();
    checks++; if (bus.in_trap !== 1'b1) begin errors++; $display("FAIL rstmid_in_trap got %b want 1", bus.in_trap); end
    rd(CSR_MIP, r); checks++; if (r !== 32'h0002_0000) begin errors++; $display("FAIL rstmid_pend got %h want %h", r, 32'h0002_0000); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.in_trap !== 1'b0) begin errors++; $display("FAIL rstmid_trap_clr got %b want 0", bus.in_trap); end
    rd(CSR_MIP, r);     checks++; if (r !== 32'h0) begin errors++; $display("FAIL rstmid_mip got %h want %h", r, 32'h0); end
    rd(CSR_MSTATUS, r); checks++; if (r !== 32'h0) begin errors++; $display("FAIL rstmid_mstatus got %h want %h", r, 32'h0); end
    rd(CSR_MTVEC, r);   checks++; if (r !== 32'h8000_0100) begin errors++; $display("FAIL rstmid_mtvec got %h want %h", r, 32'h8000_0100); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_vectored();
    test_mip_sw();
    test_level();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
